patch_gather: RTL and testbench

// - Upstream stage of the 32x32-array conv engine. For one output pixel (out_y, out_x), gathers
//   the KxK x c_in input window from the feature-map buffer into the patch buffer.
// - Patch layout: byte addr = kpos*c_in + c, with kpos = ky*K + kx.
// - Fetches 32 channels per wide read. Out-of-image taps are written as zero padding

---
 rtl/patch_gather_pkg.sv | 39 +++
 rtl/patch_gather_if.sv | 46 ++++
 rtl/patch_gather.sv | 193 +++++++++++++++++++
 tb/tb_patch_gather.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/patch_gather_pkg.sv
// Shared constants, gather FSM state encoding and lane-mask helpers for the
// patch gather stage of the conv engine.
package patch_gather_pkg;

  localparam int LANES    = 32;
  localparam int FM_AW    = 20;
  localparam int PATCH_AW = 13;
  localparam int DW       = LANES * 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_TAP       = 3'd2,
    S_RD_ISSUE  = 3'd3,
    S_RD_WRITE  = 3'd4,
    S_PAD_WRITE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Bit j set iff lane j still carries a real channel of this chunk.
  function automatic logic [LANES-1:0] lane_mask(input logic [11:0] rem);
    logic [LANES-1:0] m;
    m = '0;
    for (int j = 0; j < LANES; j++) begin
      m[j] = (12'(j) < rem);
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] byte_expand(input logic [LANES-1:0] m);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++) begin
      w[j*8 +: 8] = {8{m[j]}};
    end
    return w;
  endfunction

endpackage

// File: rtl/patch_gather_if.sv
// Bundles the patch gather config/start/status signals, the feature-map read
// port and the patch-buffer write port. Names carry the gather block's view.
interface patch_gather_if;
  import patch_gather_pkg::*;

  // Strobe semantics, no backpressure anywhere: i_start is sampled only while
  // the block is idle; o_fm_rd_en presents o_fm_rd_addr for one cycle and
  // i_fm_rd_data must hold that word exactly one cycle later; o_patch_wr_en
  // commits the masked bytes of o_patch_wr_data at o_patch_wr_addr that cycle.
  logic                i_start;
  logic [10:0]         i_c_in;
  logic [3:0]          i_kernel_size;
  logic [1:0]          i_stride;
  logic [1:0]          i_pad;
  logic [9:0]          i_in_h;
  logic [9:0]          i_in_w;
  logic [9:0]          i_out_y;
  logic [9:0]          i_out_x;

  logic [FM_AW-1:0]    o_fm_rd_addr;
  logic                o_fm_rd_en;
  logic [DW-1:0]       i_fm_rd_data;

  logic                o_patch_wr_en;
  logic [PATCH_AW-1:0] o_patch_wr_addr;
  logic [DW-1:0]       o_patch_wr_data;
  logic [LANES-1:0]    o_patch_wr_mask;

  logic                o_busy;
  logic                o_done;

  modport master (
    output i_start, i_c_in, i_kernel_size, i_stride, i_pad,
           i_in_h, i_in_w, i_out_y, i_out_x, i_fm_rd_data,
    input  o_fm_rd_addr, o_fm_rd_en, o_patch_wr_en, o_patch_wr_addr,
           o_patch_wr_data, o_patch_wr_mask, o_busy, o_done
  );

  modport slave (
    input  i_start, i_c_in, i_kernel_size, i_stride, i_pad,
           i_in_h, i_in_w, i_out_y, i_out_x, i_fm_rd_data,
    output o_fm_rd_addr, o_fm_rd_en, o_patch_wr_en, o_patch_wr_addr,
           o_patch_wr_data, o_patch_wr_mask, o_busy, o_done
  );

endinterface

// File: rtl/patch_gather.sv
// Gathers the KxK x c_in input window of one output pixel into the patch
// buffer, 32 channels per word, writing zero padding for out-of-image taps.
module patch_gather
  import patch_gather_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  patch_gather_if.slave  bus,
  output state_t         o_dbg_state
);

  state_t              r_state;

  logic [10:0]         r_cin;
  logic                r_k3;
  logic                r_s2;
  logic [1:0]          r_pad;
  logic [9:0]          r_in_h;
  logic [9:0]          r_in_w;
  logic [9:0]          r_out_y;
  logic [9:0]          r_out_x;
  logic [6:0]          r_cw;

  logic [1:0]          r_ky;
  logic [1:0]          r_kx;
  logic [5:0]          r_chunk;
  logic [PATCH_AW-1:0] r_kpos_base;

  logic                r_fm_rd_en;
  logic [FM_AW-1:0]    r_fm_rd_addr;
  logic                r_wr_en;
  logic                r_wr_fm;
  logic [PATCH_AW-1:0] r_wr_addr;
  logic [LANES-1:0]    r_wr_mask;
  logic                r_busy;
  logic                r_done;

  logic [11:0]         w_oy_sc;
  logic [11:0]         w_ox_sc;
  logic [11:0]         w_iy;
  logic [11:0]         w_ix;
  logic                w_in_bounds;
  logic [FM_AW-1:0]    w_pix;
  logic [FM_AW-1:0]    w_fm_addr;
  logic [PATCH_AW-1:0] w_patch_addr;
  logic [11:0]         w_rem;
  logic [LANES-1:0]    w_mask;
  logic [11:0]         w_cin_round;
  logic                w_last_chunk;
  logic                w_last_kx;
  logic                w_last_ky;

  // Tap coordinates in 12-bit two's complement; bit 11 flags a negative tap.
  assign w_oy_sc = r_s2 ? {1'b0, r_out_y, 1'b0} : {2'b00, r_out_y};
  assign w_ox_sc = r_s2 ? {1'b0, r_out_x, 1'b0} : {2'b00, r_out_x};
  assign w_iy    = w_oy_sc - {10'd0, r_pad} + {10'd0, r_ky};
  assign w_ix    = w_ox_sc - {10'd0, r_pad} + {10'd0, r_kx};

  assign w_in_bounds = !w_iy[11] && !w_ix[11] &&
                       (w_iy < {2'b00, r_in_h}) && (w_ix < {2'b00, r_in_w});

  assign w_pix     = {10'd0, w_iy[9:0]} * {10'd0, r_in_w} + {10'd0, w_ix[9:0]};
  assign w_fm_addr = w_pix * {13'd0, r_cw} + {14'd0, r_chunk};

  assign w_patch_addr = r_kpos_base + {2'b00, r_chunk, 5'd0};
  assign w_rem        = {1'b0, r_cin} - {1'b0, r_chunk, 5'd0};
  assign w_mask       = lane_mask(w_rem);
  assign w_cin_round  = {1'b0, r_cin} + 12'd31;

  assign w_last_chunk = ({1'b0, r_chunk} == (r_cw - 7'd1));
  assign w_last_kx    = r_k3 ? (r_kx == 2'd2) : 1'b1;
  assign w_last_ky    = r_k3 ? (r_ky == 2'd2) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cin        <= '0;
      r_k3         <= 1'b0;
      r_s2         <= 1'b0;
      r_pad        <= '0;
      r_in_h       <= '0;
      r_in_w       <= '0;
      r_out_y      <= '0;
      r_out_x      <= '0;
      r_cw         <= '0;
      r_ky         <= '0;
      r_kx         <= '0;
      r_chunk      <= '0;
      r_kpos_base  <= '0;
      r_fm_rd_en   <= 1'b0;
      r_fm_rd_addr <= '0;
      r_wr_en      <= 1'b0;
      r_wr_fm      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_mask    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Config is captured on the accepting edge so later input changes cannot leak in.
          if (bus.i_start) begin
            r_cin   <= bus.i_c_in;
            r_k3    <= (bus.i_kernel_size == 4'd3);
            r_s2    <= (bus.i_stride == 2'd2);
            r_pad   <= bus.i_pad;
            r_in_h  <= bus.i_in_h;
            r_in_w  <= bus.i_in_w;
            r_out_y <= bus.i_out_y;
            r_out_x <= bus.i_out_x;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end

        S_INIT: begin
          r_cw        <= w_cin_round[11:5];
          r_ky        <= '0;
          r_kx        <= '0;
          r_chunk     <= '0;
          r_kpos_base <= '0;
          r_state     <= S_TAP;
        end

        S_TAP: begin
          r_wr_addr <= w_patch_addr;
          r_wr_mask <= w_mask;
          if (w_in_bounds) begin
            r_fm_rd_en   <= 1'b1;
            r_fm_rd_addr <= w_fm_addr;
            r_state      <= S_RD_ISSUE;
          end else begin
            r_wr_en <= 1'b1;
            r_state <= S_PAD_WRITE;
          end
        end

        S_RD_ISSUE: begin
          r_fm_rd_en <= 1'b0;
          r_wr_en    <= 1'b1;
          r_wr_fm    <= 1'b1;
          r_state    <= S_RD_WRITE;
        end

        S_RD_WRITE, S_PAD_WRITE: begin
          r_wr_en <= 1'b0;
          r_wr_fm <= 1'b0;
          if (!w_last_chunk) begin
            r_chunk <= r_chunk + 6'd1;
          end else begin
            r_chunk     <= '0;
            r_kpos_base <= r_kpos_base + {2'b00, r_cin};
            if (!w_last_kx) begin
              r_kx <= r_kx + 2'd1;
            end else begin
              r_kx <= '0;
              if (!w_last_ky) r_ky <= r_ky + 2'd1;
            end
          end
          if (w_last_chunk && w_last_kx && w_last_ky) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_TAP;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data is only valid in the write cycle, so it passes straight to the patch port.
  assign bus.o_patch_wr_data = r_wr_fm ? (bus.i_fm_rd_data & byte_expand(r_wr_mask)) : '0;

  assign bus.o_fm_rd_en      = r_fm_rd_en;
  assign bus.o_fm_rd_addr    = r_fm_rd_addr;
  assign bus.o_patch_wr_en   = r_wr_en;
  assign bus.o_patch_wr_addr = r_wr_addr;
  assign bus.o_patch_wr_mask = r_wr_mask;
  assign bus.o_busy          = r_busy;
  assign bus.o_done          = r_done;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_patch_gather.sv
// Directed bench for patch_gather: a window-level model builds the expected
// read/write streams, one negedge process compares every strobe against them.
module tb_patch_gather;
  import patch_gather_pkg::*;

  typedef struct packed {
    logic [PATCH_AW-1:0] addr;
    logic [LANES-1:0]    mask;
    logic [DW-1:0]       data;
  } wr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  patch_gather_if bus();
  state_t dbg_state;

  patch_gather dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  wr_t              exp_q[$];
  logic [FM_AW-1:0] exp_rd_q[$];
  int n_cmp     = 0;
  int n_fail    = 0;
  int exp_busy  = 0;
  int busy_cnt  = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Feature-map contents: a per-address byte pattern; garbage when no read is pending.
  function automatic logic [DW-1:0] fm_word(input logic [FM_AW-1:0] a);
    logic [DW-1:0] w;
    for (int j = 0; j < LANES; j++) begin
      w[j*8 +: 8] = 8'((int'(a) * 37 + j * 11 + 90) & 255);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.o_fm_rd_en) bus.i_fm_rd_data <= fm_word(bus.o_fm_rd_addr);
    else                bus.i_fm_rd_data <= {8{32'hDEADBEEF}};
  end

  // ---------------- behavioural model ----------------
  task automatic build_model(input int cin, input int ks, input int st, input int pd,
                             input int h, input int w, input int oy, input int ox);
    int k, cw, iy, ix, rem, nl, a;
    wr_t e;
    exp_q.delete();
    exp_rd_q.delete();
    k  = (ks == 3) ? 3 : 1;
    cw = (cin + 31) / 32;
    exp_busy = 1;
    for (int ky = 0; ky < k; ky++) begin
      for (int kx = 0; kx < k; kx++) begin
        for (int ch = 0; ch < cw; ch++) begin
          iy  = oy * st - pd + ky;
          ix  = ox * st - pd + kx;
          rem = cin - ch * 32;
          nl  = (rem < 32) ? rem : 32;
          e.mask = '0;
          for (int j = 0; j < nl; j++) e.mask[j] = 1'b1;
          e.addr = PATCH_AW'((ky * k + kx) * cin + ch * 32);
          e.data = '0;
          if (iy >= 0 && iy < h && ix >= 0 && ix < w) begin
            a = (iy * w + ix) * cw + ch;
            exp_rd_q.push_back(FM_AW'(a));
            for (int j = 0; j < nl; j++) e.data[j*8 +: 8] = fm_word(FM_AW'(a)) >> (j * 8);
            exp_busy += 3;
          end else begin
            exp_busy += 2;
          end
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_fm_rd_en) begin
        if (exp_rd_q.size() == 0) check("unexpected_fm_read", 1, 0);
        else check("fm_rd_addr", DW'(bus.o_fm_rd_addr), DW'(exp_rd_q.pop_front()));
      end
      if (bus.o_patch_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_patch_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("patch_wr_addr", DW'(bus.o_patch_wr_addr), DW'(e.addr));
          check("patch_wr_mask", DW'(bus.o_patch_wr_mask), DW'(e.mask));
          check("patch_wr_data", bus.o_patch_wr_data, e.data);
        end
      end
      if (bus.o_done) begin
        done_cnt++;
        check("busy_low_at_done", DW'(bus.o_busy), 0);
        check("writes_left_at_done", DW'(exp_q.size()), 0);
        check("reads_left_at_done", DW'(exp_rd_q.size()), 0);
        check("busy_cycles", DW'(busy_cnt), DW'(exp_busy));
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cfg(input int cin, input int ks, input int st, input int pd,
                           input int h, input int w, input int oy, input int ox);
    bus.i_c_in        = 11'(cin);
    bus.i_kernel_size = 4'(ks);
    bus.i_stride      = 2'(st);
    bus.i_pad         = 2'(pd);
    bus.i_in_h        = 10'(h);
    bus.i_in_w        = 10'(w);
    bus.i_out_y       = 10'(oy);
    bus.i_out_x       = 10'(ox);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start_done;
    int n;
    start_done = done_cnt;
    n = 0;
    while (done_cnt == start_done && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, DW'(done_cnt - start_done), 1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    bus.i_start = 1'b0;
    drive_cfg(32, 3, 1, 1, 8, 8, 4, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", DW'(dbg_state), DW'(S_IDLE));
    check("rst_busy", DW'(bus.o_busy), 0);
    check("rst_done", DW'(bus.o_done), 0);
    check("rst_rd_en", DW'(bus.o_fm_rd_en), 0);
    check("rst_wr_en", DW'(bus.o_patch_wr_en), 0);
    check("rst_wr_data", bus.o_patch_wr_data, 0);
    rst = 1'b0;

    // T1 interior; config changed right after start must not matter
    build_model(32, 3, 1, 1, 8, 8, 4, 4);
    check("t1_model_writes", DW'(exp_q.size()), 9);
    check("t1_model_busy", DW'(exp_busy), 28);
    check("t1_model_last_addr", DW'(exp_q[8].addr), 256);
    pulse_start();
    drive_cfg(5, 1, 2, 0, 2, 2, 0, 0);
    wait_done("t1");

    // T2 corner
    build_model(32, 3, 1, 1, 8, 8, 0, 0);
    check("t2_model_reads", DW'(exp_rd_q.size()), 4);
    check("t2_model_first_read", DW'(exp_rd_q[0]), 0);
    drive_cfg(32, 3, 1, 1, 8, 8, 0, 0);
    pulse_start();
    wait_done("t2");

    // T3 c_in = 3
    build_model(3, 3, 1, 1, 8, 8, 2, 2);
    check("t3_model_mask", DW'(exp_q[0].mask), 32'h7);
    check("t3_model_last_addr", DW'(exp_q[8].addr), 24);
    drive_cfg(3, 3, 1, 1, 8, 8, 2, 2);
    pulse_start();
    wait_done("t3");

    // T4 c_in = 64, 1x1
    build_model(64, 1, 1, 0, 4, 5, 1, 2);
    check("t4_model_rd0", DW'(exp_rd_q[0]), 14);
    check("t4_model_rd1", DW'(exp_rd_q[1]), 15);
    check("t4_model_wr1_addr", DW'(exp_q[1].addr), 32);
    drive_cfg(64, 1, 1, 0, 4, 5, 1, 2);
    pulse_start();
    wait_done("t4");

    // T5 stride 2
    build_model(32, 3, 2, 1, 8, 8, 3, 3);
    check("t5_model_reads", DW'(exp_rd_q.size()), 9);
    drive_cfg(32, 3, 2, 1, 8, 8, 3, 3);
    pulse_start();
    wait_done("t5");

    // Partial last chunk with corner padding: c_in = 40 gives masks ff..ff then ff
    build_model(40, 3, 1, 1, 6, 7, 0, 6);
    check("t7_model_mask1", DW'(exp_q[1].mask), 32'hFF);
    drive_cfg(40, 3, 1, 1, 6, 7, 0, 6);
    pulse_start();
    wait_done("t7");

    // T6 reset after the 4th write
    build_model(32, 3, 1, 1, 8, 8, 4, 4);
    drive_cfg(32, 3, 1, 1, 8, 8, 4, 4);
    wr_cnt = 0;
    pulse_start();
    n = 0;
    while (wr_cnt < 4 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_reached_4_writes", DW'(wr_cnt), 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_rd_q.delete();
    rst = 1'b0;
    begin
      int ev;
      ev = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.o_patch_wr_en || bus.o_done || bus.o_busy || bus.o_fm_rd_en) ev++;
      end
      check("t6_quiet_after_reset", DW'(ev), 0);
    end
    check("t6_state_idle", DW'(dbg_state), DW'(S_IDLE));
    build_model(32, 3, 1, 1, 8, 8, 4, 4);
    pulse_start();
    wait_done("t6_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
